// File: rtl/ex_wb_stage_if.sv
// Execute/writeback stage bus: upstream-register operands and control in,
// register-file writeback port and stall out.
interface ex_wb_stage_if #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] gp_rdata1_address_in;
  logic [ADDR_W-1:0] gp_rdata2_address_in;
  logic [DATA_W-1:0] aluA_in;
  logic [DATA_W-1:0] aluB_in;
  logic [2:0]        alu_ctrl_in;
  logic              gp_reg_wb_in;

  logic [DATA_W-1:0] gp_wdata;
  logic [ADDR_W-1:0] gp_waddr;
  logic              gp_we;
  logic              zero_out;
  logic              stall;

  modport master (
    output gp_rdata1_address_in,
    output gp_rdata2_address_in,
    output aluA_in,
    output aluB_in,
    output alu_ctrl_in,
    output gp_reg_wb_in,
    input  gp_wdata,
    input  gp_waddr,
    input  gp_we,
    input  zero_out,
    input  stall
  );

  modport slave (
    input  gp_rdata1_address_in,
    input  gp_rdata2_address_in,
    input  aluA_in,
    input  aluB_in,
    input  alu_ctrl_in,
    input  gp_reg_wb_in,
    output gp_wdata,
    output gp_waddr,
    output gp_we,
    output zero_out,
    output stall
  );
endinterface

// File: rtl/ex_wb_stage.sv
// Execute/writeback stage: single-cycle ALU plus iterative shift-add multiply,
// self-forwarding of the pending result and a stall to the upstream register.
module ex_wb_stage #(
  parameter int DATA_W   = 10,
  parameter int ADDR_W   = 3,
  parameter int MUL_ITER = 10
) (
  input  logic         clk,
  input  logic         reset,
  ex_wb_stage_if.slave bus
);

  localparam int CNT_W = (MUL_ITER > 1) ? $clog2(MUL_ITER) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MUL_ITER - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t state, state_next;

  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W-1:0] waddr_q;
  logic              we_q;
  logic              zero_q;

  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] acc;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] cap_rd;
  logic              cap_wb;

  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [3:0]        shamt;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] acc_step;
  logic              load_mul;
  logic              mul_done;
  logic              stall_c;

  // The only result not yet in the register file is our own registered one.
  always_comb begin
    op_a = bus.aluA_in;
    op_b = bus.aluB_in;
    if (we_q && (waddr_q == bus.gp_rdata1_address_in)) op_a = wdata_q;
    if (we_q && (waddr_q == bus.gp_rdata2_address_in)) op_b = wdata_q;
  end

  always_comb begin
    shamt   = op_b[3:0];
    alu_res = '0;
    case (bus.alu_ctrl_in)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SLL:  alu_res = (int'(shamt) >= DATA_W) ? '0 : (op_a << shamt);
      OP_SRL:  alu_res = (int'(shamt) >= DATA_W) ? '0 : (op_a >> shamt);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    acc_step = acc;
    if (mplier[0]) acc_step = acc + mcand;
  end

  always_comb begin
    state_next = state;
    load_mul   = 1'b0;
    mul_done   = 1'b0;
    stall_c    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.alu_ctrl_in == OP_MUL) begin
          load_mul   = 1'b1;
          stall_c    = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (count == LAST_ITER) begin
          mul_done   = 1'b1;
          state_next = IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Stall drops in the final BUSY cycle so upstream advances as the product is written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdata_q <= '0;
      waddr_q <= '0;
      we_q    <= 1'b0;
      zero_q  <= 1'b0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      count   <= '0;
      cap_rd  <= '0;
      cap_wb  <= 1'b0;
    end else if (load_mul) begin
      mcand  <= op_a;
      mplier <= op_b;
      acc    <= '0;
      count  <= '0;
      cap_rd <= bus.gp_rdata1_address_in;
      cap_wb <= bus.gp_reg_wb_in;
      we_q   <= 1'b0;
    end else if (state == BUSY) begin
      acc    <= acc_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (mul_done) begin
        count   <= '0;
        waddr_q <= cap_rd;
        we_q    <= cap_wb;
        if (cap_wb) begin
          wdata_q <= acc_step;
          zero_q  <= (acc_step == '0);
        end
      end else begin
        count <= count + CNT_W'(1);
        we_q  <= 1'b0;
      end
    end else begin
      waddr_q <= bus.gp_rdata1_address_in;
      we_q    <= bus.gp_reg_wb_in;
      if (bus.gp_reg_wb_in) begin
        wdata_q <= alu_res;
        zero_q  <= (alu_res == '0);
      end
    end
  end

  assign bus.gp_wdata = wdata_q;
  assign bus.gp_waddr = waddr_q;
  assign bus.gp_we    = we_q;
  assign bus.zero_out = zero_q;
  assign bus.stall    = stall_c;

endmodule

// File: tb/tb_ex_wb_stage.sv
// Directed self-checking bench for ex_wb_stage: reset, ALU ops, forwarding,
// shifts, multiply latency/stall and reset during a multiply.
module tb_ex_wb_stage;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  ex_wb_stage_if #(.DATA_W(10), .ADDR_W(3)) bus ();

  ex_wb_stage #(.DATA_W(10), .ADDR_W(3), .MUL_ITER(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] rs1, input logic [2:0] rs2, input logic [9:0] a,
                               input logic [9:0] b, input logic [2:0] ctrl, input logic wb);
    bus.gp_rdata1_address_in = rs1;
    bus.gp_rdata2_address_in = rs2;
    bus.aluA_in              = a;
    bus.aluB_in              = b;
    bus.alu_ctrl_in          = ctrl;
    bus.gp_reg_wb_in         = wb;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkWrite(input string tag, input logic [9:0] data, input logic [2:0] addr,
                            input logic we, input logic zero);
    checkOutput({tag, "_wdata"}, 32'(bus.gp_wdata), 32'(data));
    checkOutput({tag, "_waddr"}, 32'(bus.gp_waddr), 32'(addr));
    checkOutput({tag, "_we"}, 32'(bus.gp_we), 32'(we));
    checkOutput({tag, "_zero"}, 32'(bus.zero_out), 32'(zero));
  endtask

  // Presents a MUL and walks the 11-edge sequence, checking stall and write enable each cycle.
  task automatic runMul(input string tag, input logic [2:0] rs1, input logic [2:0] rs2,
                        input logic [9:0] a, input logic [9:0] b, input logic [9:0] product);
    applyStimulus(rs1, rs2, a, b, 3'b111, 1'b1);
    #1;
    checkOutput({tag, "_stall_c1"}, 32'(bus.stall), 32'd1);
    for (int i = 1; i <= 9; i++) begin
      step();
      checkOutput($sformatf("%s_we_e%0d", tag, i), 32'(bus.gp_we), 32'd0);
      checkOutput($sformatf("%s_stall_e%0d", tag, i), 32'(bus.stall), 32'd1);
    end
    step();
    checkOutput({tag, "_we_e10"}, 32'(bus.gp_we), 32'd0);
    checkOutput({tag, "_stall_e10"}, 32'(bus.stall), 32'd0);
    step();
    checkWrite({tag, "_done"}, product, rs1, 1'b1, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    applyStimulus(3'd0, 3'd0, 10'd0, 10'd0, 3'b000, 1'b0);
    #12;
    checkWrite("por", 10'd0, 3'd0, 1'b0, 1'b0);
    checkOutput("por_stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Build nonzero outputs, then reset mid-cycle with no edge.
    step();
    applyStimulus(3'd2, 3'd1, 10'd5, 10'd7, 3'b000, 1'b1);
    step();
    checkWrite("pre_rst", 10'd12, 3'd2, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1 checkWrite("async_rst", 10'd0, 3'd0, 1'b0, 1'b0);
    #1 reset = 1'b0;

    applyStimulus(3'd3, 3'd0, 10'h3FF, 10'd1, 3'b000, 1'b1);
    step();
    checkWrite("add_wrap", 10'd0, 3'd3, 1'b1, 1'b1);

    applyStimulus(3'd2, 3'd1, 10'd5, 10'd7, 3'b000, 1'b1);
    step();
    checkOutput("fwd_add", 32'(bus.gp_wdata), 32'd12);
    applyStimulus(3'd2, 3'd4, 10'd0, 10'd2, 3'b001, 1'b1);
    step();
    checkWrite("fwd_sub", 10'd10, 3'd2, 1'b1, 1'b0);
    applyStimulus(3'd2, 3'd1, 10'd5, 10'd7, 3'b000, 1'b0);
    step();
    checkWrite("bubble", 10'd10, 3'd2, 1'b0, 1'b0);
    applyStimulus(3'd2, 3'd4, 10'd0, 10'd2, 3'b001, 1'b1);
    step();
    checkOutput("nofwd_sub", 32'(bus.gp_wdata), 32'h3FE);

    applyStimulus(3'd1, 3'd0, 10'h001, 10'd9, 3'b101, 1'b1);
    step();
    checkOutput("sll9", 32'(bus.gp_wdata), 32'h200);
    applyStimulus(3'd3, 3'd0, 10'h001, 10'd12, 3'b101, 1'b1);
    step();
    checkWrite("sll12", 10'd0, 3'd3, 1'b1, 1'b1);
    applyStimulus(3'd5, 3'd0, 10'h200, 10'd9, 3'b110, 1'b1);
    step();
    checkOutput("srl9", 32'(bus.gp_wdata), 32'h001);
    applyStimulus(3'd6, 3'd0, 10'h3AA, 10'h0FF, 3'b100, 1'b1);
    step();
    checkOutput("xor", 32'(bus.gp_wdata), 32'h355);
    applyStimulus(3'd7, 3'd0, 10'h3AA, 10'h0FF, 3'b010, 1'b1);
    step();
    checkOutput("and", 32'(bus.gp_wdata), 32'h0AA);
    applyStimulus(3'd4, 3'd0, 10'h3AA, 10'h0FF, 3'b011, 1'b1);
    step();
    checkOutput("or", 32'(bus.gp_wdata), 32'h3FF);

    runMul("mul1", 3'd5, 3'd0, 10'd25, 10'd30, 10'h2EE);
    runMul("mul2", 3'd6, 3'd7, 10'd40, 10'd40, 10'd576);

    // Reset after four multiply iterations.
    applyStimulus(3'd1, 3'd0, 10'd3, 10'd3, 3'b111, 1'b1);
    for (int i = 0; i < 5; i++) step();
    checkOutput("midmul_stall", 32'(bus.stall), 32'd1);
    #1 reset = 1'b1;
    #1 checkOutput("rst_mul_stall", 32'(bus.stall), 32'd1);
    checkOutput("rst_mul_we", 32'(bus.gp_we), 32'd0);
    applyStimulus(3'd2, 3'd3, 10'd2, 10'd3, 3'b000, 1'b1);
    #1 checkOutput("rst_add_stall", 32'(bus.stall), 32'd0);
    reset = 1'b0;
    step();
    checkWrite("post_rst_add", 10'd5, 3'd2, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_wb_stage.md
Name: ex_wb_stage

Overview:
- Execute/writeback stage directly downstream of the fetch/decode-to-execute pipeline register.
- Consumes the registered operands, ALU control, register addresses and writeback flag.
- Computes the 10-bit result: single-cycle for most ops, iterative shift-add multiply for MUL.
- Registers the result, destination address and write enable for the general-purpose register file.
- Forwards its own pending result into the next instruction and drives a stall back to the upstream register's enable.

Parameters:
- DATA_W, 10, operand/result width
- ADDR_W, 3, register address width
- MUL_ITER, 10, multiply iterations (equals DATA_W)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- gp_rdata1_address_in  input  3  rs1 address; also the destination register (rd = rs1)
- gp_rdata2_address_in  input  3  rs2 address
- aluA_in  input  10  operand A from the upstream register
- aluB_in  input  10  operand B from the upstream register
- alu_ctrl_in  input  3  operation select
- gp_reg_wb_in  input  1  instruction writes a result
- gp_wdata  output  10  registered result to the register file
- gp_waddr  output  3  registered destination address
- gp_we  output  1  registered write enable
- zero_out  output  1  registered (gp_wdata == 0), updated only when gp_we is set
- stall  output  1  combinational; upstream register enable = ~stall

Behaviour:
- Reset (async, any state, including mid-MUL): gp_wdata=0, gp_waddr=0, gp_we=0, zero_out=0, FSM=IDLE, iteration count=0, multiply accumulator=0.
- Forwarding (combinational, applied to operands before use):
  - opA = (gp_we && gp_waddr == gp_rdata1_address_in) ? gp_wdata : aluA_in.
  - opB is the same comparison using gp_rdata2_address_in and aluB_in.
- alu_ctrl_in encoding:
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR.
  - 101 SLL by opB[3:0]; 110 SRL (logical) by opB[3:0]. Shift amounts of 10..15 yield 0.
  - 111 MUL.
  - ADD/SUB/MUL results are truncated to the low 10 bits, with no carry or overflow output.
- Single-cycle ops (FSM IDLE, ctrl != 111): at the next edge, gp_wdata=result, gp_waddr=gp_rdata1_address_in, gp_we=gp_reg_wb_in. Latency is 1 cycle and stall=0.
- gp_we=0 bubble: gp_wdata and zero_out hold their previous values, gp_waddr is still updated.
- FSM states:
  - IDLE: if ctrl==111, load multiplicand=opA, multiplier=opB, acc=0, count=0, capture rd and wb; go BUSY. gp_we=0 at that edge.
  - BUSY: each edge does: if multiplier[0], acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; count++. gp_we=0 on every edge except the final one.
  - BUSY with count==MUL_ITER-1: that edge performs the last iteration, writes gp_wdata = final acc (low 10 bits), gp_waddr/gp_we = captured values, and returns to IDLE.
- stall = (IDLE && alu_ctrl_in==111) || (BUSY && count != MUL_ITER-1).
  - stall is high for 10 cycles and low during the last BUSY cycle, so upstream advances on the same edge the MUL result is written.
  - Total MUL latency: 11 edges from first presentation.
- Inputs are ignored while BUSY: the upstream register holds them stable, and only the operands latched at load are used.
- Back-to-back MULs: the second MUL is presented in the cycle after completion; it sees forwarding from the just-written result and starts a new 11-edge sequence.

Test Plan:
- Reset: assert reset mid-cycle with nonzero outputs -> all outputs 0 immediately without a clock edge; stall=0 with ctrl=000.
- ADD: A=10'h3FF, B=1, ctrl=000, wb=1, rs1=3 -> next edge gp_wdata=0, gp_waddr=3, gp_we=1, zero_out=1.
- Forward: cycle 1 ADD 5+7 into r2; cycle 2 SUB with rs1=2, aluA_in=0 (stale), B=2 -> gp_wdata=10; repeat with wb=0 on cycle 1 -> gp_wdata=10'h3FE.
- Shifts: A=10'h001, B=9, SLL -> 10'h200; B=12 -> 0; A=10'h200, B=9, SRL -> 1.
- MUL: A=25, B=30, rs1=5, wb=1 -> stall high 10 cycles, gp_we=0 throughout, 11th edge gp_wdata=750 (10'h2EE), gp_we=1; then A=B=40 -> 1600 mod 1024 = 576.
- Reset mid-MUL: reset at iteration 4 -> FSM IDLE, stall follows the current ctrl, no write occurs; a subsequent ADD completes in 1 cycle.
